ram_fifo_ctrl: RTL

Streaming FIFO controller wrapped around the team's simple dual-port RAM (registered read, 1-cycle latency, independent read/write address ports). Accepts a valid/ready input stream and generates RAM write/read strobes and addresses. Hides RAM read latency with a 2-entry output skid buffer, so a valid/ready output stream runs at 1 word/cycle. Sits directly upstream of the RAM and downstream of any producer; the RAM holds the data and this block holds all pointers and flags.

---
 rtl/ram_fifo_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller for a registered-read dual-port RAM.
// Holds pointers and occupancy; a 2-entry skid buffer hides the RAM read latency.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_write,
    output logic [ADDR_SIZE-1:0]  ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_read,
    output logic [ADDR_SIZE-1:0]  ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [ADDR_SIZE:0]    count,
    output logic                  full,
    output logic                  empty
);

    localparam int CW = ADDR_SIZE + 1;
    localparam logic [CW-1:0]        DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]        ONE_C    = CW'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_LAST = ADDR_SIZE'(DEPTH - 1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE  = ADDR_SIZE'(1);

    logic [ADDR_SIZE-1:0]  wr_ptr;
    logic [ADDR_SIZE-1:0]  rd_ptr;
    logic [CW-1:0]         mem_count;
    logic                  rd_pending;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;
    logic [1:0]            skid_count;

    logic                  push;
    logic                  pop;
    logic                  read_issue;
    logic [2:0]            skid_load;

    // Both streams transfer a word on a clock edge where valid && ready;
    // s_ready depends only on registered state (and reset), never on m_ready.
    always_comb begin
        s_ready    = !reset && (mem_count < DEPTH_C);
        m_valid    = (skid_count != 2'd0);
        m_data     = skid0;
        push       = s_valid && s_ready;
        pop        = m_valid && m_ready;
        // Occupancy the skid buffer will reach if nothing new is read.
        skid_load  = {1'b0, skid_count} + {2'b00, rd_pending} - {2'b00, pop};
        read_issue = !reset && (mem_count != '0) && (skid_load < 3'd2);

        ram_write   = push;
        ram_wr_addr = wr_ptr;
        ram_data_in = s_data;
        ram_read    = read_issue;
        ram_rd_addr = rd_ptr;

        count = mem_count + CW'(rd_pending) + CW'(skid_count);
        empty = (count == '0);
        full  = (mem_count == DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            if (read_issue)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            case ({push, read_issue})
                2'b10:   mem_count <= mem_count + ONE_C;
                2'b01:   mem_count <= mem_count - ONE_C;
                default: mem_count <= mem_count;
            endcase
            rd_pending <= read_issue;
        end
    end

    // A return arriving in the same cycle as a pop lands behind whatever remains.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid0      <= '0;
            skid1      <= '0;
            skid_count <= 2'd0;
        end else begin
            case ({pop, rd_pending})
                2'b01: begin
                    if (skid_count == 2'd0)
                        skid0 <= ram_data_out;
                    else
                        skid1 <= ram_data_out;
                    skid_count <= skid_count + 2'd1;
                end
                2'b10: begin
                    skid0      <= skid1;
                    skid_count <= skid_count - 2'd1;
                end
                2'b11: begin
                    if (skid_count == 2'd1) begin
                        skid0 <= ram_data_out;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= ram_data_out;
                    end
                end
                default: begin
                    skid_count <= skid_count;
                end
            endcase
        end
    end

endmodule
